ccr_reg: RTL and testbench
==========================

# ccr_reg

Condition-code register stage that sits directly downstream of the control unit's flag-enable decoder. It holds the architectural Z/N/C/V flags and updates them each cycle from the ALU flag outputs, gated per flag by the decoder's enables. It also clears the tested flag when a conditional jump is taken. A small shadow stack saves the flags on interrupt entry and restores them on RTI.

## Interface
Parameters:
- SHADOW_DEPTH, 2: number of saved-flag entries; legal values 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- z_en, n_en, c_en, v_en  in  1 each  per-flag write enables from the flag-enable decoder.
- alu_z, alu_n, alu_c, alu_v  in  1 each  flag values produced by the ALU this cycle.
- stall  in  1  freezes flag updates and jump clears.
- jmp_taken  in  1  a conditional jump resolved as taken this cycle.
- jmp_cond  in  2  flag tested by the jump: 00 Z, 01 N, 10 C, 11 V.
- int_save  in  1  interrupt entry; push the flags onto the shadow stack.
- rti_restore  in  1  RTI; pop the shadow stack into the CCR.
- ccr  out  4  registered flags {V,C,N,Z}.
- shadow_cnt  out  3  number of valid shadow entries.
- save_err  out  1  one-cycle pulse: the push was dropped.
- restore_err  out  1  one-cycle pulse: the pop was attempted with an empty stack.

## Operation
Reset:
- ccr=0000, shadow_cnt=0, save_err=0, restore_err=0.
- Shadow contents are don't-care after reset.

Next-value computation (nxt), evaluated per flag when rti_restore=0:
- If stall=1: nxt=ccr; enables and jmp_taken are ignored.
- Otherwise, start from ccr.
- If jmp_taken=1, clear the flag selected by jmp_cond.
- Then, for each flag whose enable is 1, load the matching alu_* value.
- An ALU write therefore overrides a jump clear on the same flag in the same cycle.

Restore (rti_restore=1):
- Highest priority. The CCR loads the top shadow entry and shadow_cnt decrements.
- Enables, jmp_taken and stall are ignored that cycle.
- If shadow_cnt=0: the CCR holds its value, the count stays 0, and restore_err pulses.

Save (int_save=1, rti_restore=0):
- Pushes nxt, so an ALU update in the same cycle is preserved in the saved entry.
- The CCR still loads nxt.
- If shadow_cnt=SHADOW_DEPTH: the push is dropped, the stack is unchanged, and save_err pulses.

Save and restore in the same cycle:
- Restore executes as above.
- The save is dropped and save_err pulses.

The stack is strictly LIFO; entry index = shadow_cnt-1.

## Timing
- Flag update latency is 1 cycle: inputs sampled at edge N appear on ccr after edge N.
- Push and pop take effect at the same edge as the CCR update.
- save_err and restore_err are registered and high for exactly the cycle after the offending edge.
- There is no combinational path from any input to any output.
- Reset asserted mid-operation immediately forces all outputs to their reset values and discards the shadow stack. Normal operation resumes on the first edge after rst deasserts.

## Configuration
- CCR_SHADOW_EN defined: the shadow stack, save/restore behaviour and both error outputs are as described above.
- CCR_SHADOW_EN undefined: no shadow storage is built.
  - int_save and rti_restore are ignored.
  - rti_restore no longer blocks flag updates.
  - shadow_cnt, save_err and restore_err are tied to 0.

## Test plan
- Reset, then z_en=n_en=1 with alu_z=1, alu_n=0, alu_c=1 -> ccr=0001 one cycle later; C stays 0 because c_en=0.
- ccr=0111, jmp_taken=1, jmp_cond=10 -> ccr=0011. Repeat with c_en=1, alu_c=1 in the same cycle -> ccr stays 0111.
- ccr=0000, all enables=1 with alu flags {V,C,N,Z}=1010, int_save=1 -> ccr=1010, shadow_cnt=1. Next, with all enables=1, alu=0101 -> ccr=0101. Then rti_restore=1 -> ccr=1010, shadow_cnt=0.
- SHADOW_DEPTH=2: three saves -> shadow_cnt=2 and save_err pulses on the third. Three restores -> entries return in LIFO order and restore_err pulses on the third.
- stall=1 with all enables=1, alu=1111 and jmp_taken=1 -> ccr unchanged. rti_restore=1 during the stall with shadow_cnt=1 -> the saved value is loaded.
- Mid-sequence with shadow_cnt=2 and ccr=1111, pulse rst asynchronously -> ccr=0000 and shadow_cnt=0 before the next edge. A following rti_restore -> restore_err pulses.

Source files
------------

// File: rtl/ccr_reg.sv
// ccr_reg: Z/N/C/V condition-code register with per-flag write enables, taken-jump clear and
// an optional LIFO shadow stack for interrupt save / RTI restore (built when CCR_SHADOW_EN is defined).
module ccr_reg #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       z_en,
  input  logic       n_en,
  input  logic       c_en,
  input  logic       v_en,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       stall,
  input  logic       jmp_taken,
  input  logic [1:0] jmp_cond,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [3:0] ccr,
  output logic [2:0] shadow_cnt,
  output logic       save_err,
  output logic       restore_err
);

  logic [3:0] en;
  logic [3:0] alu;
  logic [3:0] nxt;

  assign en  = {v_en, c_en, n_en, z_en};
  assign alu = {alu_v, alu_c, alu_n, alu_z};

  // ALU writes are applied after the jump clear so they win on the same flag.
  always_comb begin
    nxt = ccr;
    if (!stall) begin
      if (jmp_taken) nxt[jmp_cond] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (en[i]) nxt[i] = alu[i];
      end
    end
  end

`ifdef CCR_SHADOW_EN
  localparam int         IW    = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam logic [2:0] DEPTH = 3'(SHADOW_DEPTH);

  logic [3:0]    shadow_mem [2**IW];
  logic          has_entry;
  logic          full;
  logic          push;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  assign has_entry = (shadow_cnt != 3'd0);
  assign full      = (shadow_cnt == DEPTH);
  assign push      = int_save && !rti_restore && !full;
  assign top_idx   = IW'(shadow_cnt - 3'd1);
  assign push_idx  = IW'(shadow_cnt);

  // Entries carry no reset: only slots below shadow_cnt are ever read.
  always_ff @(posedge clk) begin
    if (push) shadow_mem[push_idx] <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr         <= 4'b0000;
      shadow_cnt  <= 3'd0;
      save_err    <= 1'b0;
      restore_err <= 1'b0;
    end else begin
      save_err    <= int_save && (rti_restore || full);
      restore_err <= rti_restore && !has_entry;
      if (rti_restore) begin
        if (has_entry) begin
          ccr        <= shadow_mem[top_idx];
          shadow_cnt <= shadow_cnt - 3'd1;
        end
      end else begin
        ccr <= nxt;
        if (push) shadow_cnt <= shadow_cnt + 3'd1;
      end
    end
  end
`else
  logic unused_shadow;
  assign unused_shadow = ^{int_save, rti_restore};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ccr <= 4'b0000;
    else     ccr <= nxt;
  end

  assign shadow_cnt  = 3'd0;
  assign save_err    = 1'b0;
  assign restore_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccr_reg.sv
// tb_ccr_reg: directed and randomized checks of ccr_reg against a flag/queue reference model.
module tb_ccr_reg;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       z_en, n_en, c_en, v_en;
  logic       alu_z, alu_n, alu_c, alu_v;
  logic       stall, jmp_taken, int_save, rti_restore;
  logic [1:0] jmp_cond;
  logic [3:0] ccr;
  logic [2:0] shadow_cnt;
  logic       save_err, restore_err;
  logic [8:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_ccr;
  logic [3:0] m_stack [$];
  logic       m_serr, m_rerr;

  ccr_reg #(.SHADOW_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .z_en(z_en), .n_en(n_en), .c_en(c_en), .v_en(v_en),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .stall(stall), .jmp_taken(jmp_taken), .jmp_cond(jmp_cond),
    .int_save(int_save), .rti_restore(rti_restore),
    .ccr(ccr), .shadow_cnt(shadow_cnt), .save_err(save_err), .restore_err(restore_err)
  );

  assign obs = {ccr, shadow_cnt, save_err, restore_err};

  always #5 clk = ~clk;

  task automatic set_in(input logic [3:0] en, input logic [3:0] alu, input logic stl,
                        input logic jmp, input logic [1:0] cond, input logic sv, input logic rs);
    {v_en, c_en, n_en, z_en}     = en;
    {alu_v, alu_c, alu_n, alu_z} = alu;
    stall       = stl;
    jmp_taken   = jmp;
    jmp_cond    = cond;
    int_save    = sv;
    rti_restore = rs;
  endtask

  task automatic model_reset();
    m_ccr  = 4'b0000;
    m_stack.delete();
    m_serr = 1'b0;
    m_rerr = 1'b0;
  endtask

  // Reference behaviour for one rising edge, from the current input values.
  task automatic model_edge();
    logic [3:0] en, alu, n;
    en  = {v_en, c_en, n_en, z_en};
    alu = {alu_v, alu_c, alu_n, alu_z};
    n   = m_ccr;
    if (!stall) begin
      for (int f = 0; f < 4; f++) begin
        if (jmp_taken && int'(jmp_cond) == f) n[f] = 1'b0;
        if (en[f]) n[f] = alu[f];
      end
    end
    m_serr = 1'b0;
    m_rerr = 1'b0;
`ifdef CCR_SHADOW_EN
    if (rti_restore) begin
      m_serr = int_save;
      if (m_stack.size() == 0) m_rerr = 1'b1;
      else                     m_ccr  = m_stack.pop_back();
    end else begin
      if (int_save) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(n);
        else                        m_serr = 1'b1;
      end
      m_ccr = n;
    end
`else
    m_ccr = n;
`endif
  endtask

  function automatic logic [8:0] model_out();
`ifdef CCR_SHADOW_EN
    return {m_ccr, 3'(m_stack.size()), m_serr, m_rerr};
`else
    return {m_ccr, 5'd0};
`endif
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_state got %b want %b", obs, 9'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_flag_update();
    set_in(4'b0011, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b0001 || obs !== model_out()) begin
      n_errors++;
      $display("FAIL flag_update got %b want ccr 0001 / %b", obs, model_out());
    end
  endtask

  task automatic test_jump_clear();
    set_in(4'b1111, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b0011) begin
      n_errors++;
      $display("FAIL jump_clear_c got %b want 0011", ccr);
    end
    set_in(4'b1111, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(4'b0100, 4'b0100, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b0111) begin
      n_errors++;
      $display("FAIL jump_vs_alu got %b want 0111", ccr);
    end
    set_in(4'b0000, 4'b1111, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b0110 || obs !== model_out()) begin
      n_errors++;
      $display("FAIL jump_clear_z got %b want ccr 0110 / %b", obs, model_out());
    end
  endtask

  task automatic test_save_restore();
    logic [3:0] want;
    set_in(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(4'b1111, 4'b1010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b1010 || obs !== model_out()) begin
      n_errors++;
      $display("FAIL save_push got %b want ccr 1010 / %b", obs, model_out());
    end
    set_in(4'b1111, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
`ifdef CCR_SHADOW_EN
    want = 4'b1010;
`else
    want = 4'b0101;
`endif
    n_checks++;
    if (ccr !== want || obs !== model_out()) begin
      n_errors++;
      $display("FAIL restore_pop got %b want ccr %b / %b", obs, want, model_out());
    end
  endtask

  task automatic test_overflow_underflow();
    logic [3:0] vals [3];
    vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1111, vals[i], 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_errors++;
        $display("FAIL save_seq %0d got %b want %b", i, obs, model_out());
      end
    end
`ifdef CCR_SHADOW_EN
    n_checks++;
    if (shadow_cnt !== 3'd2 || save_err !== 1'b1) begin
      n_errors++;
      $display("FAIL save_overflow got cnt %0d err %b want cnt 2 err 1", shadow_cnt, save_err);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_errors++;
        $display("FAIL restore_seq %0d got %b want %b", i, obs, model_out());
      end
    end
`ifdef CCR_SHADOW_EN
    n_checks++;
    if (ccr !== 4'b0001 || restore_err !== 1'b1 || shadow_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL restore_underflow got %b want ccr 0001 cnt 0 rerr 1", obs);
    end
`endif
    set_in(4'b1111, 4'b1100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (obs !== model_out()) begin
      n_errors++;
      $display("FAIL save_and_restore got %b want %b", obs, model_out());
    end
  endtask

  task automatic test_stall();
    logic [3:0] want;
    set_in(4'b1111, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    set_in(4'b1111, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ccr !== 4'b0011 || obs !== model_out()) begin
      n_errors++;
      $display("FAIL stall_hold got %b want ccr 0011 / %b", obs, model_out());
    end
    set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
`ifdef CCR_SHADOW_EN
    want = 4'b0110;
`else
    want = 4'b0011;
`endif
    n_checks++;
    if (ccr !== want || obs !== model_out()) begin
      n_errors++;
      $display("FAIL stall_restore got %b want ccr %b / %b", obs, want, model_out());
    end
  endtask

  task automatic test_async_reset();
    set_in(4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    tick();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 9'd0) begin
      n_errors++;
      $display("FAIL async_reset got %b want %b", obs, 9'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (obs !== model_out()) begin
      n_errors++;
      $display("FAIL post_reset_restore got %b want %b", obs, model_out());
    end
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (restore_err !== 1'b0 || obs !== model_out()) begin
      n_errors++;
      $display("FAIL err_pulse_width got %b want %b", obs, model_out());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      set_in(4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0), 2'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      tick();
      n_checks++;
      if (obs !== model_out()) begin
        n_errors++;
        $display("FAIL random cycle %0d got %b want %b", c, obs, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_flag_update();
    test_jump_clear();
    test_save_restore();
    test_overflow_underflow();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
